// File: rtl/bus_pkg.sv
// Shared definitions for the CPU-to-peripheral bus router: FSM state
// encoding, the default memory map and the fault read-back value.
package bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } bus_state_e;

  // Default peripheral map carried over from the old per-peripheral decode.
  localparam logic [63:0] Rom_base = 64'h0000_0000_0000_0000;
  localparam logic [63:0] Rom_size = 64'h0000_0000_0001_0000;
  localparam logic [63:0] Ram_base = 64'h0000_0000_8000_0000;
  localparam logic [63:0] Ram_size = 64'h0000_0000_1000_0000;
  localparam logic [63:0] Key_base = 64'h0000_0000_1000_0000;
  localparam logic [63:0] Key_size = 64'h0000_0000_0000_0010;
  localparam logic [63:0] Art_base = 64'h0000_0000_1000_1000;
  localparam logic [63:0] Art_size = 64'h0000_0000_0000_0010;
  localparam logic [63:0] Sdc_base = 64'h0000_0000_1000_2000;
  localparam logic [63:0] Sdc_size = 64'h0000_0000_0000_0100;

  // Returned to the CPU on unmapped, illegal or timed-out reads.
  localparam logic [63:0] DEFAULT_FAULT_DATA = 64'h0000_0000_DEAD_BEEF;

endpackage

// File: rtl/bus_decode.sv
// Address decoder: finds the region containing the address, lowest index
// winning on overlap, and returns its one-hot select and byte offset.
module bus_decode #(
  parameter int N_SLAVES = 4,
  parameter int ADDR_W   = 64
) (
  input  logic [ADDR_W-1:0]          i_address,
  input  logic [N_SLAVES*ADDR_W-1:0] i_base,
  input  logic [N_SLAVES*ADDR_W-1:0] i_size,
  output logic [N_SLAVES-1:0]        o_sel,
  output logic                       o_hit,
  output logic [ADDR_W-1:0]          o_offset
);

  // Scan from the highest index down so the lowest matching region is the
  // last one written. The (addr - base) < size form avoids base+size overflow.
  always_comb begin
    o_sel    = '0;
    o_hit    = 1'b0;
    o_offset = '0;
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      if ((i_size[i*ADDR_W +: ADDR_W] != '0) &&
          (i_address >= i_base[i*ADDR_W +: ADDR_W]) &&
          ((i_address - i_base[i*ADDR_W +: ADDR_W]) < i_size[i*ADDR_W +: ADDR_W])) begin
        o_sel    = '0;
        o_sel[i] = 1'b1;
        o_hit    = 1'b1;
        o_offset = i_address - i_base[i*ADDR_W +: ADDR_W];
      end
    end
  end

endmodule

// File: rtl/bus_router.sv
// Memory-mapped bus router: one registered decode per CPU request, a single
// request strobe toward the selected slave, a bounded wait for its ack, and
// a level done toward the CPU held until the CPU drops its enables.
//
// state   | meaning
// IDLE    | waiting for exactly one (or an illegal pair of) CPU enable
// REQ     | one-cycle s_re/s_we strobe to the selected slave
// WAIT    | slave selected, counting cycles until ack or timeout
// DONE    | done/data/fault held until both CPU enables are low
module bus_router
  import bus_pkg::*;
#(
  parameter int                         N_SLAVES   = 4,
  parameter int                         ADDR_W     = 64,
  parameter int                         DATA_W     = 64,
  parameter logic [N_SLAVES*ADDR_W-1:0] SLAVE_BASE = '0,
  parameter logic [N_SLAVES*ADDR_W-1:0] SLAVE_SIZE = '0,
  parameter int                         TIMEOUT    = 255,
  parameter logic [DATA_W-1:0]          FAULT_DATA = DATA_W'(DEFAULT_FAULT_DATA)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [ADDR_W-1:0]            bus_address,
  input  logic                         bus_read_enable,
  input  logic                         bus_write_enable,
  input  logic [DATA_W-1:0]            bus_write_data,
  output logic [DATA_W-1:0]            bus_read_data,
  output logic                         bus_read_done,
  output logic                         bus_write_done,
  output logic                         bus_fault,
  output logic [N_SLAVES-1:0]          s_sel,
  output logic                         s_re,
  output logic                         s_we,
  output logic [ADDR_W-1:0]            s_address,
  output logic [DATA_W-1:0]            s_write_data,
  input  logic [N_SLAVES-1:0]          s_ack,
  input  logic [N_SLAVES*DATA_W-1:0]   s_read_data
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  bus_state_e          r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_is_write;
  logic [N_SLAVES-1:0] r_sel;
  logic                r_re;
  logic                r_we;
  logic [ADDR_W-1:0]   r_s_addr;
  logic [DATA_W-1:0]   r_s_wdata;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_rd_done;
  logic                r_wr_done;
  logic                r_fault;

  logic [N_SLAVES-1:0] w_dec_sel;
  logic                w_dec_hit;
  logic [ADDR_W-1:0]   w_dec_offset;
  logic                w_ack_sel;
  logic [DATA_W-1:0]   w_slave_rdata;

  bus_decode #(
    .N_SLAVES (N_SLAVES),
    .ADDR_W   (ADDR_W)
  ) u_decode (
    .i_address (bus_address),
    .i_base    (SLAVE_BASE),
    .i_size    (SLAVE_SIZE),
    .o_sel     (w_dec_sel),
    .o_hit     (w_dec_hit),
    .o_offset  (w_dec_offset)
  );

  // Only the currently selected slave's ack counts; others are ignored.
  assign w_ack_sel = |(s_ack & r_sel);

  // Read data mux driven by the registered one-hot select.
  always_comb begin
    w_slave_rdata = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (r_sel[i]) w_slave_rdata = w_slave_rdata | s_read_data[i*DATA_W +: DATA_W];
    end
  end

  // Transaction FSM with timeout counter; all outputs are registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_is_write <= 1'b0;
      r_sel      <= '0;
      r_re       <= 1'b0;
      r_we       <= 1'b0;
      r_s_addr   <= '0;
      r_s_wdata  <= '0;
      r_rdata    <= '0;
      r_rd_done  <= 1'b0;
      r_wr_done  <= 1'b0;
      r_fault    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus_read_enable && bus_write_enable) begin
            r_rd_done <= 1'b1;
            r_wr_done <= 1'b1;
            r_fault   <= 1'b1;
            r_rdata   <= FAULT_DATA;
            r_state   <= ST_DONE;
          end else if (bus_read_enable || bus_write_enable) begin
            r_is_write <= bus_write_enable;
            if (w_dec_hit) begin
              r_sel     <= w_dec_sel;
              r_re      <= bus_read_enable;
              r_we      <= bus_write_enable;
              r_s_addr  <= w_dec_offset;
              r_s_wdata <= bus_write_data;
              r_state   <= ST_REQ;
            end else begin
              r_rd_done <= bus_read_enable;
              r_wr_done <= bus_write_enable;
              r_fault   <= 1'b1;
              r_rdata   <= FAULT_DATA;
              r_state   <= ST_DONE;
            end
          end
        end
        ST_REQ: begin
          r_re <= 1'b0;
          r_we <= 1'b0;
          if (w_ack_sel) begin
            if (!r_is_write) r_rdata <= w_slave_rdata;
            r_rd_done <= !r_is_write;
            r_wr_done <= r_is_write;
            r_state   <= ST_DONE;
          end else begin
            // REQ counts as the first elapsed cycle, so WAIT starts at 1.
            r_cnt   <= CNT_W'(1);
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // The ack is checked first so it wins over a coincident timeout.
          if (w_ack_sel) begin
            if (!r_is_write) r_rdata <= w_slave_rdata;
            r_rd_done <= !r_is_write;
            r_wr_done <= r_is_write;
            r_state   <= ST_DONE;
          end else if (r_cnt == CNT_W'(TIMEOUT)) begin
            r_sel     <= '0;
            r_rd_done <= !r_is_write;
            r_wr_done <= r_is_write;
            r_fault   <= 1'b1;
            r_rdata   <= FAULT_DATA;
            r_state   <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          if (!bus_read_enable && !bus_write_enable) begin
            r_cnt      <= '0;
            r_is_write <= 1'b0;
            r_sel      <= '0;
            r_s_addr   <= '0;
            r_s_wdata  <= '0;
            r_rdata    <= '0;
            r_rd_done  <= 1'b0;
            r_wr_done  <= 1'b0;
            r_fault    <= 1'b0;
            r_state    <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus_read_data  = r_rdata;
  assign bus_read_done  = r_rd_done;
  assign bus_write_done = r_wr_done;
  assign bus_fault      = r_fault;
  assign s_sel          = r_sel;
  assign s_re           = r_re;
  assign s_we           = r_we;
  assign s_address      = r_s_addr;
  assign s_write_data   = r_s_wdata;

endmodule

// File: tb/tb_bus_router.sv
// Directed bench for bus_router: hand-computed expectations for reads,
// writes, unmapped/illegal accesses, timeout and reset behaviour.
module tb_bus_router;

  localparam int NS = 4;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam logic [63:0] FD = 64'h0000_0000_DEAD_BEEF;

  // slave0 ROM 0x0000/0x1000, slave1 0x1000/0x1000, slave2 UART 0x2000/0x10,
  // slave3 0x2000/0x1000 (overlaps slave2, which must win)
  localparam logic [NS*AW-1:0] BASES = {64'h2000, 64'h2000, 64'h1000, 64'h0000};
  localparam logic [NS*AW-1:0] SIZES = {64'h1000, 64'h0010, 64'h1000, 64'h1000};

  logic               clk = 1'b0;
  logic               reset;
  logic [AW-1:0]      bus_address;
  logic               bus_read_enable;
  logic               bus_write_enable;
  logic [DW-1:0]      bus_write_data;
  logic [DW-1:0]      bus_read_data;
  logic               bus_read_done;
  logic               bus_write_done;
  logic               bus_fault;
  logic [NS-1:0]      s_sel;
  logic               s_re;
  logic               s_we;
  logic [AW-1:0]      s_address;
  logic [DW-1:0]      s_write_data;
  logic [NS-1:0]      s_ack;
  logic [NS*DW-1:0]   s_read_data;

  int n_vec = 0;
  int n_err = 0;
  int n_we  = 0;

  bus_router #(
    .N_SLAVES   (NS),
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .SLAVE_BASE (BASES),
    .SLAVE_SIZE (SIZES),
    .TIMEOUT    (8),
    .FAULT_DATA (FD)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .bus_address      (bus_address),
    .bus_read_enable  (bus_read_enable),
    .bus_write_enable (bus_write_enable),
    .bus_write_data   (bus_write_data),
    .bus_read_data    (bus_read_data),
    .bus_read_done    (bus_read_done),
    .bus_write_done   (bus_write_done),
    .bus_fault        (bus_fault),
    .s_sel            (s_sel),
    .s_re             (s_re),
    .s_we             (s_we),
    .s_address        (s_address),
    .s_write_data     (s_write_data),
    .s_ack            (s_ack),
    .s_read_data      (s_read_data)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_rd_done"}, 64'(bus_read_done), 64'd0);
    chk({tag, "_wr_done"}, 64'(bus_write_done), 64'd0);
    chk({tag, "_fault"}, 64'(bus_fault), 64'd0);
    chk({tag, "_rdata"}, bus_read_data, 64'd0);
    chk({tag, "_sel"}, 64'(s_sel), 64'd0);
    chk({tag, "_strobes"}, 64'({s_re, s_we}), 64'd0);
    chk({tag, "_s_addr"}, s_address, 64'd0);
    chk({tag, "_s_wdata"}, s_write_data, 64'd0);
  endtask

  initial begin
    reset            = 1'b1;
    bus_address      = '0;
    bus_read_enable  = 1'b0;
    bus_write_enable = 1'b0;
    bus_write_data   = '0;
    s_ack            = '0;
    s_read_data      = {64'h5555, 64'h7777, 64'h1234, 64'hAAAA};
    tick();
    tick();
    chk_idle("reset");
    reset = 1'b0;
    tick();

    // Read slave1, ack 3 cycles after the strobe -> done at cycle 5.
    bus_address     = 64'h1010;
    bus_read_enable = 1'b1;
    tick();                                    // cycle 1
    chk("rd1_s_re", 64'(s_re), 64'd1);
    chk("rd1_s_we", 64'(s_we), 64'd0);
    chk("rd1_sel", 64'(s_sel), 64'b0010);
    chk("rd1_offset", s_address, 64'h10);
    tick();                                    // cycle 2
    chk("rd1_s_re_c2", 64'(s_re), 64'd0);
    chk("rd1_sel_c2", 64'(s_sel), 64'b0010);
    tick();                                    // cycle 3
    tick();                                    // cycle 4
    chk("rd1_done_c4", 64'(bus_read_done), 64'd0);
    s_ack = 4'b0010;
    tick();                                    // cycle 5
    s_ack = '0;
    chk("rd1_done", 64'(bus_read_done), 64'd1);
    chk("rd1_data", bus_read_data, 64'h1234);
    chk("rd1_fault", 64'(bus_fault), 64'd0);
    chk("rd1_wr_done", 64'(bus_write_done), 64'd0);
    tick();
    chk("rd1_hold", 64'(bus_read_done), 64'd1);
    bus_read_enable = 1'b0;
    tick();
    chk_idle("rd1_end");

    // Write to UART (overlap with slave3: slave2 wins), enable held 50 cycles.
    bus_address      = 64'h2004;
    bus_write_data   = 64'hCAFE;
    bus_write_enable = 1'b1;
    for (int i = 1; i <= 50; i++) begin
      tick();
      if (s_we) n_we++;
      if (i == 1) begin
        chk("wr_sel", 64'(s_sel), 64'b0100);
        chk("wr_offset", s_address, 64'h4);
        chk("wr_data", s_write_data, 64'hCAFE);
        s_ack = 4'b0100;                       // same-cycle ack
      end
      if (i == 2) begin
        s_ack = '0;
        chk("wr_done_c2", 64'(bus_write_done), 64'd1);
        chk("wr_rd_done_c2", 64'(bus_read_done), 64'd0);
        chk("wr_fault", 64'(bus_fault), 64'd0);
      end
    end
    chk("wr_one_strobe", 64'(n_we), 64'd1);
    chk("wr_done_held", 64'(bus_write_done), 64'd1);
    bus_write_enable = 1'b0;
    tick();
    chk_idle("wr_end");

    // Unmapped read -> fault done at cycle 1, no select.
    bus_address     = 64'hFFFF_0000;
    bus_read_enable = 1'b1;
    tick();
    chk("unm_done", 64'(bus_read_done), 64'd1);
    chk("unm_data", bus_read_data, FD);
    chk("unm_fault", 64'(bus_fault), 64'd1);
    chk("unm_sel", 64'(s_sel), 64'd0);
    chk("unm_re", 64'(s_re), 64'd0);
    bus_read_enable = 1'b0;
    tick();
    chk_idle("unm_end");

    // Timeout: slave0 at its last byte never acks -> fault done at cycle 10.
    bus_address     = 64'h0FFF;
    bus_read_enable = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == 1) begin
        chk("to_sel", 64'(s_sel), 64'b0001);
        chk("to_offset", s_address, 64'hFFF);
      end
      if (i == 9) chk("to_done_c9", 64'(bus_read_done), 64'd0);
    end
    chk("to_done", 64'(bus_read_done), 64'd1);
    chk("to_fault", 64'(bus_fault), 64'd1);
    chk("to_data", bus_read_data, FD);
    chk("to_sel_drop", 64'(s_sel), 64'd0);
    s_ack = 4'b0001;                           // late ack in DONE
    tick();
    chk("to_late_fault", 64'(bus_fault), 64'd1);
    chk("to_late_data", bus_read_data, FD);
    bus_read_enable = 1'b0;
    s_ack = '0;
    tick();
    chk_idle("to_end");
    s_ack = 4'b0001;                           // stray ack in IDLE
    tick();
    s_ack = '0;
    chk_idle("idle_ack");

    // Ack exactly at the timeout cycle wins; foreign ack ignored meanwhile.
    bus_address     = 64'h2100;
    bus_read_enable = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == 1) begin
        chk("tw_sel", 64'(s_sel), 64'b1000);
        chk("tw_offset", s_address, 64'h100);
      end
      if (i == 3) s_ack = 4'b0001;
      if (i == 4) begin
        s_ack = '0;
        chk("tw_foreign", 64'(bus_read_done), 64'd0);
      end
      if (i == 9) s_ack = 4'b1000;
    end
    s_ack = '0;
    chk("tw_done", 64'(bus_read_done), 64'd1);
    chk("tw_fault", 64'(bus_fault), 64'd0);
    chk("tw_data", bus_read_data, 64'h5555);
    bus_read_enable = 1'b0;
    tick();
    chk_idle("tw_end");

    // Reset during WAIT, then a fresh transaction with a same-cycle ack.
    bus_address     = 64'h1008;
    bus_read_enable = 1'b1;
    tick();
    tick();
    tick();                                    // cycle 3, WAIT
    reset = 1'b1;
    tick();
    chk_idle("rst_wait");
    reset = 1'b0;
    s_ack = 4'b0010;                           // late ack seen in IDLE
    tick();
    chk("rst_new_re", 64'(s_re), 64'd1);
    chk("rst_new_done", 64'(bus_read_done), 64'd0);
    chk("rst_new_offset", s_address, 64'h8);
    tick();                                    // ack held through REQ
    s_ack = '0;
    chk("rst_new_done_c2", 64'(bus_read_done), 64'd1);
    chk("rst_new_data", bus_read_data, 64'h1234);
    chk("rst_new_fault", 64'(bus_fault), 64'd0);
    bus_read_enable = 1'b0;
    tick();
    chk_idle("rst_end");

    // Both enables: dual done with fault, no strobe.
    bus_address      = 64'h1000;
    bus_read_enable  = 1'b1;
    bus_write_enable = 1'b1;
    tick();
    chk("dual_rd_done", 64'(bus_read_done), 64'd1);
    chk("dual_wr_done", 64'(bus_write_done), 64'd1);
    chk("dual_fault", 64'(bus_fault), 64'd1);
    chk("dual_strobes", 64'({s_re, s_we}), 64'd0);
    chk("dual_sel", 64'(s_sel), 64'd0);
    tick();
    chk("dual_strobes_c2", 64'({s_re, s_we}), 64'd0);
    bus_read_enable  = 1'b0;
    bus_write_enable = 1'b0;
    tick();
    chk_idle("dual_end");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
